// File: rtl/riscv_defs.sv
// Shared definitions for the multicycle RV32I control path: opcodes, ALUOp codes,
// mux-select encodings, FSM state encoding and the control-word layout.
package riscv_defs;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_RS1   = 2'b01,
    SRCA_OLDPC = 2'b10,
    SRCA_ZERO  = 2'b11
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JALR   = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'b00,
    M2R_MDR    = 2'b01,
    M2R_PC     = 2'b10
  } m2r_e;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_REXEC    = 4'd6,
    S_IEXEC    = 4'd7,
    S_LUIEXEC  = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_e;

  typedef struct packed {
    aluop_e alu_op;
    srca_e  src_a;
    srcb_e  src_b;
    logic   iord;
    logic   mem_read;
    logic   mem_write;
    logic   ir_write;
    logic   pc_write;
    logic   pc_write_cond;
    pcsrc_e pc_source;
    logic   reg_write;
    m2r_e   mem_to_reg;
    logic   illegal;
  } ctrl_t;

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational state -> control-word table for the multicycle control FSM.
module riscv_ctrl_decode
  import riscv_defs::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.src_b    = SRCB_FOUR;
        // IR load and PC+4 commit only on the cycle memory delivers the word
        ctrl_o.ir_write = mem_ready_i;
        ctrl_o.pc_write = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.src_a = SRCA_OLDPC;
        ctrl_o.src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        ctrl_o.src_a = SRCA_RS1;
        ctrl_o.src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = M2R_MDR;
      end
      S_MEMWRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_REXEC: begin
        ctrl_o.src_a  = SRCA_RS1;
        ctrl_o.src_b  = SRCB_RS2;
        ctrl_o.alu_op = ALUOP_RTYPE;
      end
      S_IEXEC: begin
        ctrl_o.src_a  = SRCA_RS1;
        ctrl_o.src_b  = SRCB_IMM;
        ctrl_o.alu_op = ALUOP_ITYPE;
      end
      S_LUIEXEC: begin
        ctrl_o.src_a  = SRCA_ZERO;
        ctrl_o.src_b  = SRCB_IMM;
        ctrl_o.alu_op = ALUOP_RTYPE;
      end
      S_ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
      end
      S_BRANCH: begin
        ctrl_o.src_a         = SRCA_RS1;
        ctrl_o.src_b         = SRCB_RS2;
        ctrl_o.alu_op        = ALUOP_BRANCH;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JAL: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = M2R_PC;
      end
      S_JALR: begin
        ctrl_o.src_a      = SRCA_RS1;
        ctrl_o.src_b      = SRCB_IMM;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JALR;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = M2R_PC;
      end
      S_ILLEGAL: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_control.sv
// Main control FSM for the multicycle RV32I datapath: sequences each instruction,
// traps illegal opcodes and counts retired instructions.
module riscv_multicycle_control
  import riscv_defs::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter bit          HALT_ON_ILL = 1'b1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [6:0]       iOpcode,
  input  logic             iMemReady,
  output logic [1:0]       oALUOp,
  output logic [1:0]       oALUSrcA,
  output logic [1:0]       oALUSrcB,
  output logic             oIorD,
  output logic             oMemRead,
  output logic             oMemWrite,
  output logic             oIRWrite,
  output logic             oPCWrite,
  output logic             oPCWriteCond,
  output logic [1:0]       oPCSource,
  output logic             oRegWrite,
  output logic [1:0]       oMemtoReg,
  output logic             oIllegal,
  output logic [3:0]       oState,
  output logic [CNT_W-1:0] oInstrCount
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctrl_t            ctrl;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (iMemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (iOpcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_OP:              state_d = S_REXEC;
          OPC_OPIMM:           state_d = S_IEXEC;
          OPC_LUI:             state_d = S_LUIEXEC;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          OPC_JALR:            state_d = S_JALR;
          default:             state_d = HALT_ON_ILL ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (iOpcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (iMemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (iMemReady) state_d = S_FETCH;
      S_REXEC, S_IEXEC, S_LUIEXEC: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires whenever the FSM re-enters FETCH from elsewhere
  always_comb begin
    count_d = count_q;
    if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  riscv_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (iMemReady),
    .ctrl_o      (ctrl)
  );

  assign oALUOp       = ctrl.alu_op;
  assign oALUSrcA     = ctrl.src_a;
  assign oALUSrcB     = ctrl.src_b;
  assign oIorD        = ctrl.iord;
  assign oMemRead     = ctrl.mem_read;
  assign oPCWriteCond = ctrl.pc_write_cond;
  assign oPCSource    = ctrl.pc_source;
  assign oMemtoReg    = ctrl.mem_to_reg;
  assign oIllegal     = ctrl.illegal;
  assign oState       = state_q;
  assign oInstrCount  = count_q;

  // Architectural writes are suppressed for as long as reset is held
  assign oIRWrite  = ctrl.ir_write  & ~iRST;
  assign oPCWrite  = ctrl.pc_write  & ~iRST;
  assign oRegWrite = ctrl.reg_write & ~iRST;
  assign oMemWrite = ctrl.mem_write & ~iRST;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Scoreboard bench for riscv_multicycle_control: the driver queues the expected
// control word for every cycle, a negedge monitor pops and compares.
module tb_riscv_multicycle_control;
  import riscv_defs::*;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcsrc;
    logic       rw;
    logic [1:0] m2r;
    logic       ill;
    logic [3:0] cnt;
  } obs_t;

  typedef struct {
    obs_t        o;
    logic [3:0]  st2;
    logic [31:0] cnt2;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opc;
  logic        rdy;

  logic [1:0]  alu_op, src_a, src_b, pcsrc, m2r;
  logic        iord, mrd, mwr, irw, pcw, pcwc, rw, ill;
  logic [3:0]  st;
  logic [3:0]  cnt;

  logic [1:0]  alu_op2, src_a2, src_b2, pcsrc2, m2r2;
  logic        iord2, mrd2, mwr2, irw2, pcw2, pcwc2, rw2, ill2;
  logic [3:0]  st2;
  logic [31:0] cnt2;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  string       cur_tag  = "reset";
  logic [3:0]  exp_cnt1 = '0;
  logic [31:0] exp_cnt2 = '0;
  state_e      prev1 = S_FETCH;
  state_e      prev2 = S_FETCH;

  always #5 clk = ~clk;

  riscv_multicycle_control #(.CNT_W(4), .HALT_ON_ILL(1'b1)) dut (
    .iCLK(clk), .iRST(rst), .iOpcode(opc), .iMemReady(rdy),
    .oALUOp(alu_op), .oALUSrcA(src_a), .oALUSrcB(src_b), .oIorD(iord),
    .oMemRead(mrd), .oMemWrite(mwr), .oIRWrite(irw), .oPCWrite(pcw),
    .oPCWriteCond(pcwc), .oPCSource(pcsrc), .oRegWrite(rw), .oMemtoReg(m2r),
    .oIllegal(ill), .oState(st), .oInstrCount(cnt)
  );

  riscv_multicycle_control #(.CNT_W(32), .HALT_ON_ILL(1'b0)) dut_nop (
    .iCLK(clk), .iRST(rst), .iOpcode(opc), .iMemReady(rdy),
    .oALUOp(alu_op2), .oALUSrcA(src_a2), .oALUSrcB(src_b2), .oIorD(iord2),
    .oMemRead(mrd2), .oMemWrite(mwr2), .oIRWrite(irw2), .oPCWrite(pcw2),
    .oPCWriteCond(pcwc2), .oPCSource(pcsrc2), .oRegWrite(rw2), .oMemtoReg(m2r2),
    .oIllegal(ill2), .oState(st2), .oInstrCount(cnt2)
  );

  // Control word expected in each state, written out from the state table
  function automatic obs_t model(input state_e s, input logic ready, input logic in_rst);
    obs_t o;
    o = '0;
    o.st = s;
    case (s)
      S_FETCH:    begin o.mrd = 1'b1; o.src_b = 2'b01; o.irw = ready; o.pcw = ready; end
      S_DECODE:   begin o.src_a = 2'b10; o.src_b = 2'b10; end
      S_MEMADR:   begin o.src_a = 2'b01; o.src_b = 2'b10; end
      S_MEMREAD:  begin o.mrd = 1'b1; o.iord = 1'b1; end
      S_MEMWB:    begin o.rw = 1'b1; o.m2r = 2'b01; end
      S_MEMWRITE: begin o.mwr = 1'b1; o.iord = 1'b1; end
      S_REXEC:    begin o.src_a = 2'b01; o.src_b = 2'b00; o.alu_op = 2'b10; end
      S_IEXEC:    begin o.src_a = 2'b01; o.src_b = 2'b10; o.alu_op = 2'b11; end
      S_LUIEXEC:  begin o.src_a = 2'b11; o.src_b = 2'b10; o.alu_op = 2'b10; end
      S_ALUWB:    begin o.rw = 1'b1; o.m2r = 2'b00; end
      S_BRANCH:   begin o.src_a = 2'b01; o.alu_op = 2'b01; o.pcwc = 1'b1; o.pcsrc = 2'b01; end
      S_JAL:      begin o.pcw = 1'b1; o.pcsrc = 2'b01; o.rw = 1'b1; o.m2r = 2'b10; end
      S_JALR:     begin o.src_a = 2'b01; o.src_b = 2'b10; o.pcw = 1'b1; o.pcsrc = 2'b10;
                        o.rw = 1'b1; o.m2r = 2'b10; end
      S_ILLEGAL:  begin o.ill = 1'b1; end
      default: ;
    endcase
    if (in_rst) begin
      o.irw = 1'b0; o.pcw = 1'b0; o.rw = 1'b0; o.mwr = 1'b0;
    end
    return o;
  endfunction

  task automatic push(input state_e s1, input state_e s2, input logic ready, input logic in_rst);
    exp_t e;
    e.o     = model(s1, ready, in_rst);
    e.o.cnt = exp_cnt1;
    e.st2   = s2;
    e.cnt2  = exp_cnt2;
    e.tag   = cur_tag;
    sb.push_back(e);
  endtask

  task automatic step2(input state_e s1, input state_e s2, input logic ready);
    rdy = ready;
    if (s1 == S_FETCH && prev1 != S_FETCH) exp_cnt1 = exp_cnt1 + 4'd1;
    if (s2 == S_FETCH && prev2 != S_FETCH) exp_cnt2 = exp_cnt2 + 32'd1;
    prev1 = s1;
    prev2 = s2;
    push(s1, s2, ready, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic step(input state_e s, input logic ready);
    step2(s, s, ready);
  endtask

  // Asserts reset mid-cycle for one clock; both FSMs must drop to FETCH at once
  task automatic rst_step(input logic ready);
    rst = 1'b1;
    rdy = ready;
    exp_cnt1 = '0;
    exp_cnt2 = '0;
    prev1 = S_FETCH;
    prev2 = S_FETCH;
    push(S_FETCH, S_FETCH, ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      obs_t a;
      e = sb.pop_front();
      a = {st, alu_op, src_a, src_b, iord, mrd, mwr, irw, pcw, pcwc, pcsrc, rw, m2r, ill, cnt};
      n_checks++;
      if (a !== e.o) begin
        n_fail++;
        $display("FAIL %s ctrl @%0t: dut=%h expected=%h", e.tag, $time, a, e.o);
      end
      n_checks++;
      if (st2 !== e.st2 || cnt2 !== e.cnt2) begin
        n_fail++;
        $display("FAIL %s nop_dut @%0t: state=%0d count=%0d expected state=%0d count=%0d",
                 e.tag, $time, st2, cnt2, e.st2, e.cnt2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    opc = '0;
    rdy = 1'b1;
    @(posedge clk); #1;
    rst_step(1'b1);

    cur_tag = "rtype";  opc = OPC_OP;
    step(S_FETCH, 1); step(S_DECODE, 1); step(S_REXEC, 1); step(S_ALUWB, 1);

    cur_tag = "itype_fetch_wait"; opc = OPC_OPIMM;
    step(S_FETCH, 0); step(S_FETCH, 0); step(S_FETCH, 1);
    step(S_DECODE, 1); step(S_IEXEC, 1); step(S_ALUWB, 1);

    cur_tag = "load_wait"; opc = OPC_LOAD;
    step(S_FETCH, 1); step(S_DECODE, 1); step(S_MEMADR, 1);
    step(S_MEMREAD, 0); step(S_MEMREAD, 0); step(S_MEMREAD, 0);
    step(S_MEMREAD, 1); step(S_MEMWB, 1);

    cur_tag = "branch"; opc = OPC_BRANCH;
    step(S_FETCH, 1); step(S_DECODE, 1); step(S_BRANCH, 1);

    cur_tag = "jalr"; opc = OPC_JALR;
    step(S_FETCH, 1); step(S_DECODE, 1); step(S_JALR, 1);

    cur_tag = "lui"; opc = OPC_LUI;
    step(S_FETCH, 1); step(S_DECODE, 1); step(S_LUIEXEC, 1); step(S_ALUWB, 1);

    cur_tag = "jal"; opc = OPC_JAL;
    step(S_FETCH, 1); step(S_DECODE, 1); step(S_JAL, 1);

    cur_tag = "store"; opc = OPC_STORE;
    step(S_FETCH, 1); step(S_DECODE, 1); step(S_MEMADR, 1); step(S_MEMWRITE, 1);

    cur_tag = "store_reset"; opc = OPC_STORE;
    step(S_FETCH, 1); step(S_DECODE, 1); step(S_MEMADR, 1); step(S_MEMWRITE, 0);
    rst_step(1'b0);

    cur_tag = "count_wrap"; opc = OPC_BRANCH;
    for (int i = 0; i < 16; i++) begin
      step(S_FETCH, 1); step(S_DECODE, 1); step(S_BRANCH, 1);
    end

    cur_tag = "illegal"; opc = 7'b1111111;
    step(S_FETCH, 1); step(S_DECODE, 1);
    for (int i = 0; i < 100; i++) begin
      step2(S_ILLEGAL, (i % 2 == 0) ? S_FETCH : S_DECODE, 1);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
